imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Registered, handshaked immediate-extension stage for the decode pipeline; successor to the combinational immediate extender.
- Takes the full instruction word, the PC and a 3-bit format select. Produces the sign/zero-extended immediate at XLEN width, the PC-relative target (PC + imm) and an illegal-select flag.
- Sits between the instruction-fetch register and the execute stage. A 2-entry skid buffer keeps in_ready registered, with no combinational path from out_ready.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 4, width of the opaque sequence tag carried alongside each instruction.
- SHAMT_W, derived (5 when XLEN=32, 6 when XLEN=64), shift-amount field width; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of the instruction.
- in_sel  in  3  format select: 001 I, 010 S, 011 B, 100 U, 101 J, 110 I-shamt, 111 CSR zimm, 000 none.
- in_tag  in  TAG_W  sequence tag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  out  1  select was 000.
- out_tag  out  TAG_W  tag of the presented result.

Behaviour:
- Immediate formats (s = instr[31], replicated to XLEN):
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {s, instr[31:12], 12'b0}.
  - J: {s, instr[19:12], instr[20], instr[30:21], 1'b0}.
  - I-shamt: zero-extended instr[20+SHAMT_W-1:20]; instr[30] (the arithmetic-shift bit) is never included.
  - CSR zimm: zero-extended instr[19:15].
  - 000: out_imm = 0 and out_illegal = 1.
- Extension and target addition are computed at enqueue. The stored entry holds imm, target, illegal and tag.
- Latency: accept at edge N, out_valid high after edge N; 1 cycle when the stage is empty.
- Occupancy state machine:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main entry valid, in_ready=1.
  - TWO: main and skid entries valid, in_ready=0.
- Transitions (accept = in_valid & in_ready; drain = out_valid & out_ready):
  - EMPTY + accept -> ONE.
  - ONE + accept & !drain -> TWO; the new item goes to skid.
  - ONE + accept & drain -> ONE; the new item replaces main.
  - ONE + !accept & drain -> EMPTY.
  - TWO + drain -> ONE; skid moves to main. No accept is possible in this state.
- Ordering is strictly FIFO. Outputs always show the main entry.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush: at the next edge the state goes to EMPTY and in_ready goes to 1. Any input presented in the same cycle is dropped. Flush has priority over accept and drain.
- Reset: asynchronously forces EMPTY. Outputs then read out_valid=0, in_ready=1, out_imm=0, out_target=0, out_illegal=0, out_tag=0. Reset mid-transfer discards both entries.
- Data registers have no reset requirement beyond the output values above. The implementation clears them.

Test Plan:
- Reset, then in_instr=0xFFF00093, sel=001, pc=0x100 -> 1 cycle later out_valid=1, out_imm=0xFFFFFFFF, out_target=0x000000FF, out_illegal=0.
- Encodings, with out_ready=1 throughout:
  - 0xFE20AE23 sel=010 -> out_imm 0xFFFFFFFC.
  - 0xFE000CE3 sel=011 pc=0x100 -> out_imm 0xFFFFFFF8, out_target 0xF8.
  - 0x123450B7 sel=100 -> out_imm 0x12345000.
  - 0x4030D093 sel=110 -> out_imm 3.
  - instr[19:15]=11111 sel=111 -> out_imm 0x1F.
  - sel=000 -> out_imm 0, out_illegal=1.
- Backpressure with out_ready=0 and three back-to-back offers (tags 1,2,3) -> tags 1 and 2 accepted; in_ready=0 after the second; tag 3 held upstream. Raise out_ready -> outputs tags 1, 2, 3 in order, no duplicates or losses, outputs stable while stalled.
- State TWO, then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- XLEN=64: 0xFE000CE3 sel=011 -> out_imm 0xFFFFFFFFFFFFFFF8. 0x03F0D093 sel=110 -> out_imm 0x3F.
- Assert reset asynchronously between edges while in TWO -> outputs go to reset values immediately, without waiting for a clock edge. First accept after release yields 1-cycle latency.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage with a 2-entry skid buffer.
// Ports: clk/reset/flush; in_* valid/ready request (instr, pc, sel, tag);
// out_* valid/ready result (imm, target = pc + imm, illegal, tag).
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;

    logic [XLEN-1:0] new_imm;
    logic            new_ill;
    entry_t          new_entry;
    logic            accept;
    logic            drain;
    logic            s;

    // Opcode bits play no part in immediate extraction.
    logic            unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    assign s = in_instr[31];

    // Extension happens at enqueue so the stored entry is already final.
    always_comb begin
        new_imm = '0;
        new_ill = 1'b0;
        unique case (in_sel)
            3'b001: new_imm = {{(XLEN-12){s}}, in_instr[31:20]};
            3'b010: new_imm = {{(XLEN-12){s}}, in_instr[31:25],
                               in_instr[11:7]};
            3'b011: new_imm = {{(XLEN-12){s}}, in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            3'b100: new_imm = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
            3'b101: new_imm = {{(XLEN-20){s}}, in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            // Only the shamt field; bit 30 (arith select) is excluded.
            3'b110: new_imm = {{(XLEN-SHAMT_W){1'b0}},
                               in_instr[20 +: SHAMT_W]};
            3'b111: new_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            3'b000: new_ill = 1'b1;
            default: new_imm = '0;
        endcase
    end

    always_comb begin
        new_entry         = '0;
        new_entry.imm     = new_imm;
        new_entry.target  = in_pc + new_imm;
        new_entry.illegal = new_ill;
        new_entry.tag     = in_tag;
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != EMPTY) & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = new_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_d  = new_entry;
                        state_d = TWO;
                    end else if (accept && drain) begin
                        main_d  = new_entry;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready: computed from the next occupancy.
        in_ready_d = (state_d != TWO);
    end

    always_comb begin
        in_ready    = in_ready_q;
        out_valid   = (state_q != EMPTY);
        out_imm     = main_q.imm;
        out_target  = main_q.target;
        out_illegal = main_q.illegal;
        out_tag     = main_q.tag;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: random + directed check of imm_ext_pipe (XLEN 32 and 64)
// against a queue-based reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [2:0]  in_sel;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic        out_illegal;
    logic [3:0]  out_tag;

    logic        flush_w;
    logic        in_valid_w;
    logic        in_ready_w;
    logic [31:0] in_instr_w;
    logic [63:0] in_pc_w;
    logic [2:0]  in_sel_w;
    logic [3:0]  in_tag_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [63:0] out_imm_w;
    logic [63:0] out_target_w;
    logic        out_illegal_w;
    logic [3:0]  out_tag_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] target;
        logic        illegal;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_sel(in_sel),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_target(out_target),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_instr(in_instr_w), .in_pc(in_pc_w), .in_sel(in_sel_w),
        .in_tag(in_tag_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .out_imm(out_imm_w),
        .out_target(out_target_w), .out_illegal(out_illegal_w),
        .out_tag(out_tag_w)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference immediate built from field arithmetic on a sign mask.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                            input logic [2:0] sel,
                                            input int xlen);
        logic [63:0] hi;
        logic [63:0] r;
        hi = ins[31] ? ~64'd0 : 64'd0;
        case (sel)
            3'd1: r = (hi << 12) | 64'(ins >> 20);
            3'd2: r = (hi << 12) | 64'((ins >> 25) << 5)
                      | 64'((ins >> 7) & 32'h1F);
            3'd3: r = (hi << 12) | (64'(ins[7]) << 11)
                      | (64'((ins >> 25) & 32'h3F) << 5)
                      | (64'((ins >> 8) & 32'hF) << 1);
            3'd4: r = (hi << 32) | 64'(ins & 32'hFFFFF000);
            3'd5: r = (hi << 20) | (64'((ins >> 12) & 32'hFF) << 12)
                      | (64'(ins[20]) << 11)
                      | (64'((ins >> 21) & 32'h3FF) << 1);
            3'd6: r = 64'(ins >> 20) & ((xlen == 64) ? 64'd63 : 64'd31);
            3'd7: r = 64'((ins >> 15) & 32'h1F);
            default: r = 64'd0;
        endcase
        if (xlen == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] ins,
                                input logic [2:0] sel,
                                input logic [63:0] pc,
                                input logic [3:0] tg, input int xlen);
        exp_t e;
        e.imm     = ref_imm(ins, sel, xlen);
        e.target  = pc + e.imm;
        if (xlen == 32) e.target = e.target & 64'hFFFF_FFFF;
        e.illegal = (sel == 3'd0);
        e.tag     = tg;
        return e;
    endfunction

    task automatic check_all();
        check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("out_imm", 64'(out_imm), q[0].imm);
            check_eq("out_target", 64'(out_target), q[0].target);
            check_eq("out_illegal", 64'(out_illegal), 64'(q[0].illegal));
            check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
    endtask

    // One clock of the 32-bit instance; called at posedge+1.
    task automatic step(input logic iv, input logic [31:0] ins,
                        input logic [2:0] sel, input logic [31:0] pc,
                        input logic [3:0] tg, input logic ordy,
                        input logic fl);
        logic acc;
        logic drn;
        in_valid  = iv;
        in_instr  = ins;
        in_sel    = sel;
        in_pc     = pc;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (drn) q.delete(0);
            if (acc) q.push_back(mk(ins, sel, 64'(pc), tg, 32));
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_all();
    endtask

    task automatic check_reset_vals(input string p);
        check_eq({p, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({p, "_ready"}, 64'(in_ready), 64'd1);
        check_eq({p, "_imm"}, 64'(out_imm), 64'd0);
        check_eq({p, "_target"}, 64'(out_target), 64'd0);
        check_eq({p, "_illegal"}, 64'(out_illegal), 64'd0);
        check_eq({p, "_tag"}, 64'(out_tag), 64'd0);
        check_eq({p, "_valid64"}, 64'(out_valid_w), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        in_sel = '0;
        in_tag = '0;
        out_ready = 1'b0;
        flush_w = 1'b0;
        in_valid_w = 1'b0;
        in_instr_w = '0;
        in_pc_w = '0;
        in_sel_w = '0;
        in_tag_w = '0;
        out_ready_w = 1'b1;
        #1;
        check_reset_vals("rst");
        #11;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        // Directed encodings, out_ready high.
        step(1, 32'hFFF00093, 3'b001, 32'h100, 4'd1, 1'b1, 1'b0);
        check_eq("i_valid", 64'(out_valid), 64'd1);
        check_eq("i_imm", 64'(out_imm), 64'hFFFFFFFF);
        check_eq("i_target", 64'(out_target), 64'hFF);
        check_eq("i_illegal", 64'(out_illegal), 64'd0);
        step(1, 32'hFE20AE23, 3'b010, 32'h0, 4'd2, 1'b1, 1'b0);
        check_eq("s_imm", 64'(out_imm), 64'hFFFFFFFC);
        step(1, 32'hFE000CE3, 3'b011, 32'h100, 4'd3, 1'b1, 1'b0);
        check_eq("b_imm", 64'(out_imm), 64'hFFFFFFF8);
        check_eq("b_target", 64'(out_target), 64'hF8);
        step(1, 32'h123450B7, 3'b100, 32'h0, 4'd4, 1'b1, 1'b0);
        check_eq("u_imm", 64'(out_imm), 64'h12345000);
        step(1, 32'h4030D093, 3'b110, 32'h0, 4'd5, 1'b1, 1'b0);
        check_eq("shamt_imm", 64'(out_imm), 64'd3);
        step(1, 32'h000F8073, 3'b111, 32'h0, 4'd6, 1'b1, 1'b0);
        check_eq("zimm_imm", 64'(out_imm), 64'h1F);
        step(1, 32'hFFFFFFFF, 3'b000, 32'h40, 4'd7, 1'b1, 1'b0);
        check_eq("none_imm", 64'(out_imm), 64'd0);
        check_eq("none_illegal", 64'(out_illegal), 64'd1);
        step(0, 32'h0, 3'b000, 32'h0, 4'd0, 1'b1, 1'b0);

        // Backpressure: tags 1,2 accepted, 3 held upstream.
        step(1, 32'h00100093, 3'b001, 32'h10, 4'd1, 1'b0, 1'b0);
        step(1, 32'h00200093, 3'b001, 32'h20, 4'd2, 1'b0, 1'b0);
        check_eq("bp_ready_full", 64'(in_ready), 64'd0);
        step(1, 32'h00300093, 3'b001, 32'h30, 4'd3, 1'b0, 1'b0);
        check_eq("bp_hold_tag", 64'(out_tag), 64'd1);
        step(1, 32'h00300093, 3'b001, 32'h30, 4'd3, 1'b1, 1'b0);
        check_eq("bp_tag2", 64'(out_tag), 64'd2);
        step(1, 32'h00300093, 3'b001, 32'h30, 4'd3, 1'b1, 1'b0);
        check_eq("bp_tag3", 64'(out_tag), 64'd3);
        step(0, 32'h0, 3'b000, 32'h0, 4'd0, 1'b1, 1'b0);
        check_eq("bp_drained", 64'(out_valid), 64'd0);

        // Flush from TWO with a concurrent offer.
        step(1, 32'h00A00093, 3'b001, 32'h0, 4'd10, 1'b0, 1'b0);
        step(1, 32'h00B00093, 3'b001, 32'h0, 4'd11, 1'b0, 1'b0);
        step(1, 32'h00900093, 3'b001, 32'h0, 4'd9, 1'b0, 1'b1);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_ready", 64'(in_ready), 64'd1);
        step(0, 32'h0, 3'b000, 32'h0, 4'd0, 1'b1, 1'b0);
        step(0, 32'h0, 3'b000, 32'h0, 4'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 3'($urandom), $urandom, 4'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset while full.
        step(1, 32'h00C00093, 3'b001, 32'h0, 4'd12, 1'b0, 1'b0);
        step(1, 32'h00D00093, 3'b001, 32'h0, 4'd13, 1'b0, 1'b0);
        step(1, 32'h00E00093, 3'b001, 32'h0, 4'd14, 1'b0, 1'b0);
        check_eq("pre_areset_ready", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("areset");
        q.delete();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        step(1, 32'h00500093, 3'b001, 32'h8, 4'd5, 1'b0, 1'b0);
        check_eq("post_rst_latency", 64'(out_valid), 64'd1);
        check_eq("post_rst_target", 64'(out_target), 64'hD);
        step(0, 32'h0, 3'b000, 32'h0, 4'd0, 1'b1, 1'b0);

        // XLEN=64 instance, always draining.
        in_valid_w = 1'b1;
        in_instr_w = 32'hFE000CE3;
        in_sel_w = 3'b011;
        in_pc_w = 64'h100;
        in_tag_w = 4'd1;
        @(posedge clk);
        #1;
        check_eq("x64_b_valid", 64'(out_valid_w), 64'd1);
        check_eq("x64_b_imm", out_imm_w, 64'hFFFFFFFFFFFFFFF8);
        check_eq("x64_b_target", out_target_w, 64'hF8);
        in_instr_w = 32'h03F0D093;
        in_sel_w = 3'b110;
        in_tag_w = 4'd2;
        @(posedge clk);
        #1;
        check_eq("x64_shamt_imm", out_imm_w, 64'h3F);
        check_eq("x64_shamt_tag", 64'(out_tag_w), 64'd2);
        for (int i = 0; i < 100; i++) begin
            in_instr_w = $urandom;
            in_sel_w = 3'($urandom);
            in_pc_w = {$urandom, $urandom};
            in_tag_w = 4'($urandom);
            e = mk(in_instr_w, in_sel_w, in_pc_w, in_tag_w, 64);
            @(posedge clk);
            #1;
            check_eq("x64_ready", 64'(in_ready_w), 64'd1);
            check_eq("x64_valid", 64'(out_valid_w), 64'd1);
            check_eq("x64_imm", out_imm_w, e.imm);
            check_eq("x64_target", out_target_w, e.target);
            check_eq("x64_illegal", 64'(out_illegal_w), 64'(e.illegal));
            check_eq("x64_tag", 64'(out_tag_w), 64'(e.tag));
        end
        in_valid_w = 1'b0;
        @(posedge clk);
        #1;
        check_eq("x64_idle", 64'(out_valid_w), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
